// File: rtl/processador_sica_if.sv
// SICA memory bus: word address, read/write data and access strobes between CPU and RAM.
interface processador_sica_if;
    localparam int unsigned W = 32;

    logic [W-1:0] MAR;
    logic [W-1:0] MBR_in;
    logic [W-1:0] MBR_out;
    logic         mem_enable;
    logic         mem_op;

    modport master (output MAR, output MBR_out, output mem_enable, output mem_op, input MBR_in);
    modport slave  (input MAR, input MBR_out, input mem_enable, input mem_op, output MBR_in);
endinterface

// File: rtl/processador_sica.sv
// SICA: 32-bit multi-cycle load/store CPU (FETCH/DECODE/EXEC/[MEM]/WB) over a MAR/MBR bus,
// with its register file as a child instance so rf.regs stays visible for debug.
module processador_sica_rf #(
    parameter int unsigned NREGS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);
    logic [31:0] regs [NREGS];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (we && (32'(waddr) < NREGS)) begin
            regs[waddr] <= wdata;
        end
    end

    // Indices beyond NREGS read as zero and are never written.
    assign rdata_a = (32'(ra) < NREGS) ? regs[ra] : '0;
    assign rdata_b = (32'(rb) < NREGS) ? regs[rb] : '0;
endmodule

module processador_sica #(
    parameter int unsigned NREGS = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    processador_sica_if.master        bus,
    input  logic [31:0]               input_data,
    output logic [31:0]               output_data
);
    localparam int unsigned W = 32;

    localparam logic [3:0] OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_LW  = 4'h4;
    localparam logic [3:0] OP_SW  = 4'h5, OP_IN  = 4'h6, OP_OUT = 4'h7, OP_BEQ = 4'h8;
    localparam logic [3:0] OP_BLT = 4'h9, OP_JMP = 4'hA, OP_MOV = 4'hB, OP_AND = 4'hC;
    localparam logic [3:0] OP_OR  = 4'hD, OP_SLT = 4'hE;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    state_t       state;
    logic [W-1:0] PC;
    logic [W-1:0] ir;
    logic [W-1:0] mar;
    logic [W-1:0] mbr_out;
    logic [W-1:0] result;
    logic         taken;

    logic [3:0]   op, rd, rs, rt;
    logic [W-1:0] sext_imm, target, rdata_a, rdata_b;
    logic [W-1:0] alu_c, pc_next_c;
    logic         taken_c, rf_we_c;

    assign op       = ir[31:28];
    assign rd       = ir[27:24];
    assign rs       = ir[23:20];
    assign rt       = ir[19:16];
    assign sext_imm = {{16{ir[15]}}, ir[15:0]};
    assign target   = {16'b0, ir[15:0]};

    processador_sica_rf #(.NREGS(NREGS)) rf (
        .clock   (clock),
        .reset   (reset),
        .we      (rf_we_c),
        .waddr   (rd),
        .wdata   ((op == OP_LW) ? bus.MBR_in : result),
        .ra      (rs),
        .rb      (rt),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // Result and branch decision computed in EXEC, consumed in WB.
    always_comb begin
        alu_c   = '0;
        taken_c = 1'b0;
        case (op)
            OP_LDI: alu_c = sext_imm;
            OP_ADD: alu_c = rdata_a + rdata_b;
            OP_SUB: alu_c = rdata_a - rdata_b;
            OP_IN:  alu_c = input_data;
            OP_OUT: alu_c = rdata_a;
            OP_BEQ: taken_c = (rdata_a == rdata_b);
            OP_BLT: taken_c = ($signed(rdata_a) < $signed(rdata_b));
            OP_JMP: taken_c = 1'b1;
            OP_MOV: alu_c = rdata_a;
            OP_AND: alu_c = rdata_a & rdata_b;
            OP_OR:  alu_c = rdata_a | rdata_b;
            OP_SLT: alu_c = W'($signed(rdata_a) < $signed(rdata_b));
            default: ;
        endcase
    end

    assign pc_next_c = taken ? target : PC + W'(1);

    always_comb begin
        rf_we_c = 1'b0;
        if (reset && state == WB) begin
            case (op)
                OP_LDI, OP_ADD, OP_SUB, OP_LW, OP_IN,
                OP_MOV, OP_AND, OP_OR, OP_SLT: rf_we_c = 1'b1;
                default: rf_we_c = 1'b0;
            endcase
        end
    end

    // Strobes are gated by reset so an aborted instruction can never touch RAM.
    assign bus.mem_enable = reset && (state == FETCH || state == MEM);
    assign bus.mem_op     = reset && (state == MEM) && (op == OP_SW);
    assign bus.MAR        = mar;
    assign bus.MBR_out    = mbr_out;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= FETCH;
            PC          <= '0;
            ir          <= '0;
            mar         <= '0;
            mbr_out     <= '0;
            result      <= '0;
            taken       <= 1'b0;
            output_data <= '0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    ir    <= bus.MBR_in;
                    state <= EXEC;
                end
                EXEC: begin
                    result <= alu_c;
                    taken  <= taken_c;
                    if (op == OP_LW || op == OP_SW) begin
                        mar     <= rdata_a + sext_imm;
                        mbr_out <= rdata_b;
                        state   <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: state <= WB;
                WB: begin
                    if (op == OP_OUT) output_data <= result;
                    PC    <= pc_next_c;
                    mar   <= pc_next_c;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_processador_sica.sv
// Bench for processador_sica: RAM model plus an instruction-level ISA reference model,
// driving the reference program, directed corner programs and randomly generated programs.
module tb_processador_sica;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] input_data = '0;
    logic [31:0] output_data;

    processador_sica_if bus ();

    processador_sica #(.NREGS(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.master),
        .input_data  (input_data),
        .output_data (output_data)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [256];
    logic [31:0] img [256];

    // RAM reloads its image while reset is low; registered read.
    always @(posedge clock) begin
        if (!reset) begin
            ram <= img;
        end else if (bus.mem_enable) begin
            if (bus.mem_op) ram[bus.MAR[7:0]] <= bus.MBR_out;
            else            bus.MBR_in <= ram[bus.MAR[7:0]];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt,
                                        input logic [15:0] imm);
        enc = {4'(op), 4'(rd), 4'(rs), 4'(rt), imm};
    endfunction

    // ISA-level reference model state
    logic [31:0] mregs [16];
    logic [31:0] mmem  [256];
    logic [31:0] mout, mpc, mhalt;
    int          mcyc;

    task automatic model_step(input logic [31:0] inp);
        logic [31:0] w, a, b, sx, tgt;
        int rd, rs, rt;
        w   = mmem[mpc[7:0]];
        rd  = int'(w[27:24]);
        rs  = int'(w[23:20]);
        rt  = int'(w[19:16]);
        a   = mregs[rs];
        b   = mregs[rt];
        sx  = {{16{w[15]}}, w[15:0]};
        tgt = {16'b0, w[15:0]};
        mcyc += 4;
        mpc  = mpc + 1;
        case (w[31:28])
            4'h1: mregs[rd] = sx;
            4'h2: mregs[rd] = a + b;
            4'h3: mregs[rd] = a - b;
            4'h4: begin mregs[rd] = mmem[8'(a + sx)]; mcyc += 1; end
            4'h5: begin mmem[8'(a + sx)] = b; mcyc += 1; end
            4'h6: mregs[rd] = inp;
            4'h7: mout = a;
            4'h8: if (a == b) mpc = tgt;
            4'h9: if ($signed(a) < $signed(b)) mpc = tgt;
            4'hA: mpc = tgt;
            4'hB: mregs[rd] = a;
            4'hC: mregs[rd] = a & b;
            4'hD: mregs[rd] = a | b;
            4'hE: mregs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mmem = img;
        mout = '0;
        mpc  = '0;
        mcyc = 0;
    endtask

    // Execute from img until a jump-to-self is the next instruction.
    task automatic model_run(input logic [31:0] inp);
        logic [31:0] w;
        model_reset();
        mhalt = 32'hFFFF_FFFF;
        for (int s = 0; s < 2000; s++) begin
            w = mmem[mpc[7:0]];
            if (w[31:28] == 4'hA && {16'b0, w[15:0]} == mpc) begin
                mhalt = mpc;
                break;
            end
            model_step(inp);
        end
    endtask

    task automatic run_and_check(input string name, input logic [31:0] inp, input int hold);
        int cyc, nz, bad;
        model_run(inp);
        reset      = 1'b0;
        input_data = inp;
        repeat (hold) begin
            @(posedge clock); #1;
            check({name, ":rst_pc"},  dut.PC, 32'd0);
            check({name, ":rst_en"},  32'(bus.mem_enable), 32'd0);
            check({name, ":rst_out"}, output_data, 32'd0);
        end
        nz = 0;
        for (int i = 0; i < 16; i++) if (dut.rf.regs[i] !== 32'd0) nz++;
        check({name, ":rst_regs"}, 32'(nz), 32'd0);

        reset = 1'b1;
        cyc   = 0;
        while (dut.PC !== mhalt && cyc < 3000) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({name, ":cycles_to_halt"}, 32'(cyc), 32'(mcyc));

        bad = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (dut.PC !== mhalt || (bus.mem_enable && bus.mem_op)) bad++;
        end
        check({name, ":halt_loop"}, 32'(bad), 32'd0);

        for (int i = 0; i < 16; i++)
            check($sformatf("%s:r%0d", name, i), dut.rf.regs[i], mregs[i]);
        check({name, ":output"}, output_data, mout);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== mmem[i]) bad++;
        check({name, ":ram_words_differing"}, 32'(bad), 32'd0);
    endtask

    task automatic load_reference();
        for (int i = 0; i < 256; i++) img[i] = '0;
        img[0]  = enc(6, 0, 0, 0, 16'd0);
        img[1]  = enc(1, 1, 0, 0, 16'd6);
        img[2]  = enc(1, 2, 0, 0, 16'd10);
        img[3]  = enc(2, 5, 1, 2, 16'd0);
        img[4]  = enc(3, 4, 0, 5, 16'd0);
        img[5]  = enc(9, 0, 0, 5, 16'd12);
        img[6]  = enc(5, 0, 6, 4, 16'd1);
        img[7]  = enc(1, 3, 0, 0, 16'hFFFF);
        img[8]  = enc(2, 3, 5, 3, 16'd0);
        img[9]  = enc(5, 0, 6, 3, 16'd2);
        img[10] = enc(1, 3, 0, 0, 16'd1);
        img[11] = enc(10, 0, 0, 0, 16'd17);
        img[12] = enc(1, 3, 0, 0, 16'd1);
        img[13] = enc(5, 0, 6, 3, 16'd1);
        img[14] = enc(5, 0, 6, 5, 16'd2);
        img[15] = enc(1, 3, 0, 0, 16'd2);
        img[16] = enc(0, 0, 0, 0, 16'd0);
        img[17] = enc(7, 0, 3, 0, 16'd0);
        img[18] = enc(10, 0, 0, 0, 16'd18);
    endtask

    // Builds a forward-only random program; branch/jump targets skip one junk word.
    task automatic gen_random(output logic [31:0] inp);
        logic [31:0] w, old;
        int op, rd, rs, rt;
        logic [15:0] imm;
        logic [7:0] tgt;
        for (int i = 0; i < 256; i++) img[i] = (i >= 128) ? $urandom : 32'd0;
        inp = $urandom;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            op  = int'($urandom_range(0, 15));
            rd  = int'($urandom_range(0, 15));
            rs  = int'($urandom_range(0, 15));
            rt  = int'($urandom_range(0, 15));
            imm = 16'($urandom);
            if (op == 8 || op == 9 || op == 10) imm = 16'(mpc + 2);
            if (op == 4 || op == 5) begin
                tgt = 8'($urandom_range(128, 255));
                imm[7:0] = tgt - mregs[rs][7:0];
            end
            w   = enc(op, rd, rs, rt, imm);
            old = mpc;
            img[old[7:0]]  = w;
            mmem[old[7:0]] = w;
            model_step(inp);
            if (mpc == old + 2) begin
                w = $urandom;
                img[8'(old + 1)]  = w;
                mmem[8'(old + 1)] = w;
            end
        end
        img[mpc[7:0]] = enc(10, 0, 0, 0, mpc[15:0]);
    endtask

    initial begin
        logic [31:0] rin;

        // Reference program, input 10: BLT taken path
        load_reference();
        run_and_check("s1_in10", 32'd10, 3);
        check("s1:mem1", ram[1], 32'd1);
        check("s1:mem2", ram[2], 32'd16);
        check("s1:out",  output_data, 32'd2);
        check("s1:r5",   dut.rf.regs[5], 32'd16);
        check("s1:r4",   dut.rf.regs[4], 32'hFFFF_FFFA);

        // Input 20: fall-through path
        run_and_check("s2_in20", 32'd20, 3);
        check("s2:mem1", ram[1], 32'd4);
        check("s2:mem2", ram[2], 32'd15);
        check("s2:out",  output_data, 32'd1);
        check("s2:r5",   dut.rf.regs[5], 32'd16);
        check("s2:r4",   dut.rf.regs[4], 32'd4);

        // Rerun scenario 1 after scenario 2 with a long reset
        run_and_check("s3_rerun", 32'd10, 8);
        check("s3:out", output_data, 32'd2);
        check("s3:mem2", ram[2], 32'd16);

        // Abort mid-program, then full run
        reset = 1'b1;
        repeat ($urandom_range(6, 45)) @(posedge clock);
        #1;
        run_and_check("s4_abort", 32'd20, 3);

        // Signed SUB wrap and signed BLT
        for (int i = 0; i < 256; i++) img[i] = '0;
        img[0] = enc(1, 1, 0, 0, 16'd1);
        img[1] = enc(3, 2, 3, 1, 16'd0);
        img[2] = enc(9, 0, 2, 3, 16'd5);
        img[3] = enc(1, 4, 0, 0, 16'd7);
        img[4] = enc(10, 0, 0, 0, 16'd4);
        img[5] = enc(1, 4, 0, 0, 16'd9);
        img[6] = enc(10, 0, 0, 0, 16'd6);
        run_and_check("s6_signed", 32'd0, 3);
        check("s6:r2", dut.rf.regs[2], 32'hFFFF_FFFF);
        check("s6:r4", dut.rf.regs[4], 32'd9);
        check("s6:pc", dut.PC, 32'd6);

        // Random programs against the ISA model
        for (int t = 0; t < 6; t++) begin
            gen_random(rin);
            run_and_check($sformatf("rand%0d", t), rin, 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
